// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl
//   Initiator-side controller for the 32x20 main memory. It fetches instructions
//   sequentially from the PC. For the copy-input opcode, it also fetches the
//   trailing immediate word. MEM-stage one-word stores share the same memory port.
//   The fetched words are presented to the IF/ID pipeline register.
//
// Ports
//   Clock, Resetn             clock, asynchronous active-low reset
//   stall                     ID not ready: hold a valid instruction, no new fetch
//   flush, flush_pc           redirect the PC
//   st_req, st_addr, st_data  store request, held until st_ack
//   st_ack                    one-cycle pulse when the store has been committed
//   mem_addr/mem_data/mem_wr_en  memory port (memory writes on negedge Clock)
//   mem_q                     combinational read data for mem_addr
//   instr, imm, instr_valid, imm_valid, pc_out   fetch results to ID
//
// Configuration
//   FETCH_PERF_EN  adds saturating counters fetch_cnt and store_cnt
//
// state   | meaning
// S_FETCH | fetch the word at pc (or hold while stalled)
// S_IMM   | fetch the immediate word of a two-word instruction
// S_STORE | memory port drives the latched store for one cycle
module instr_fetch_ctrl #(
    parameter int                ADDR_W     = 5,
    parameter int                DATA_W     = 20,
    parameter logic [3:0]        IMM_OPCODE = 4'b1111,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_ack,
`ifdef FETCH_PERF_EN
    output logic [15:0]       fetch_cnt,
    output logic [15:0]       store_cnt,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wr_en,
    input  logic [DATA_W-1:0] mem_q,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] imm,
    output logic              instr_valid,
    output logic              imm_valid,
    output logic [ADDR_W-1:0] pc_out
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_IMM   = 2'd1,
        S_STORE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    state_e              ret_q, ret_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic                iv_q, iv_d;
    logic                imv_q, imv_d;
    logic                ack_q, ack_d;
    logic [ADDR_W-1:0]   st_addr_q, st_addr_d;
    logic [DATA_W-1:0]   st_data_q, st_data_d;
    logic                store_go;
    logic                instr_done;

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        imm_d      = imm_q;
        iv_d       = iv_q;
        imv_d      = imv_q;
        ack_d      = 1'b0;
        st_addr_d  = st_addr_q;
        st_data_d  = st_data_q;
        instr_done = 1'b0;
        // A request still high during its own ack cycle is the one just stored.
        store_go   = st_req && !ack_q;

        unique case (state_q)
            S_FETCH: begin
                if (flush) begin
                    pc_d  = flush_pc;
                    iv_d  = 1'b0;
                    imv_d = 1'b0;
                end else if (store_go) begin
                    st_addr_d = st_addr;
                    st_data_d = st_data;
                    ret_d     = S_FETCH;
                    state_d   = S_STORE;
                end else if (stall && iv_q) begin
                    // ID holds the current instruction; keep everything
                end else begin
                    instr_d = mem_q;
                    pc_d    = pc_q + ADDR_W'(1);
                    imv_d   = 1'b0;
                    if (mem_q[DATA_W-1 -: 4] == IMM_OPCODE) begin
                        iv_d    = 1'b0;
                        state_d = S_IMM;
                    end else begin
                        iv_d       = 1'b1;
                        instr_done = 1'b1;
                    end
                end
            end
            S_IMM: begin
                if (flush) begin
                    pc_d    = flush_pc;
                    iv_d    = 1'b0;
                    imv_d   = 1'b0;
                    state_d = S_FETCH;
                end else if (store_go) begin
                    st_addr_d = st_addr;
                    st_data_d = st_data;
                    ret_d     = S_IMM;
                    state_d   = S_STORE;
                end else begin
                    imm_d      = mem_q;
                    pc_d       = pc_q + ADDR_W'(1);
                    iv_d       = 1'b1;
                    imv_d      = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_STORE: begin
                ack_d   = 1'b1;
                state_d = ret_q;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= S_FETCH;
            ret_q     <= S_FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            imm_q     <= '0;
            iv_q      <= 1'b0;
            imv_q     <= 1'b0;
            ack_q     <= 1'b0;
            st_addr_q <= '0;
            st_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            imm_q     <= imm_d;
            iv_q      <= iv_d;
            imv_q     <= imv_d;
            ack_q     <= ack_d;
            st_addr_q <= st_addr_d;
            st_data_q <= st_data_d;
        end
    end

    // The port follows the state register directly, so reset drops wr_en at once.
    assign mem_wr_en   = (state_q == S_STORE);
    assign mem_addr    = mem_wr_en ? st_addr_q : pc_q;
    assign mem_data    = mem_wr_en ? st_data_q : '0;

    assign st_ack      = ack_q;
    assign instr       = instr_q;
    assign imm         = imm_q;
    assign instr_valid = iv_q;
    assign imm_valid   = imv_q;
    assign pc_out      = pc_q;

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_cnt_q, fetch_cnt_d;
    logic [15:0] store_cnt_q, store_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        store_cnt_d = store_cnt_q;
        if (instr_done && fetch_cnt_q != 16'hFFFF) fetch_cnt_d = fetch_cnt_q + 16'd1;
        if (ack_d && store_cnt_q != 16'hFFFF)      store_cnt_d = store_cnt_q + 16'd1;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            fetch_cnt_q <= '0;
            store_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            store_cnt_q <= store_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign store_cnt = store_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: a 32x20 memory model plus expected-response queues
// for presented instructions and for memory writes.
module tb_instr_fetch_ctrl;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        stall;
    logic        flush;
    logic [4:0]  flush_pc;
    logic        st_req;
    logic [4:0]  st_addr;
    logic [19:0] st_data;
    logic        st_ack;
    logic [4:0]  mem_addr;
    logic [19:0] mem_data;
    logic        mem_wr_en;
    logic [19:0] mem_q;
    logic [19:0] instr;
    logic [19:0] imm;
    logic        instr_valid;
    logic        imm_valid;
    logic [4:0]  pc_out;
`ifdef FETCH_PERF_EN
    logic [15:0] fetch_cnt;
    logic [15:0] store_cnt;
`endif

    instr_fetch_ctrl dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .stall       (stall),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .st_req      (st_req),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_ack      (st_ack),
`ifdef FETCH_PERF_EN
        .fetch_cnt   (fetch_cnt),
        .store_cnt   (store_cnt),
`endif
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_wr_en   (mem_wr_en),
        .mem_q       (mem_q),
        .instr       (instr),
        .imm         (imm),
        .instr_valid (instr_valid),
        .imm_valid   (imm_valid),
        .pc_out      (pc_out)
    );

    always #5 Clock = ~Clock;

    function automatic logic [19:0] init_word(input int i);
        case (i)
            0:       return 20'hF0000;
            1:       return 20'h00003;
            2:       return 20'h01230;
            3:       return 20'hF4444;
            4:       return 20'h00044;
            5:       return 20'hF5555;
            6:       return 20'h00066;
            7:       return 20'h07777;
            31:      return 20'hF2000;
            default: return 20'h00100 + 20'(i);
        endcase
    endfunction

    logic [19:0] mem [0:31];
    logic        mem_loaded = 1'b0;
    assign mem_q = mem[mem_addr];

    always @(negedge Clock) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else if (mem_wr_en) begin
            mem[mem_addr] <= mem_data;
        end
    end

    typedef struct packed {
        logic [19:0] instr;
        logic [19:0] imm;
        logic        imv;
        logic [4:0]  pc;
    } exp_instr_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [19:0] data;
    } exp_store_t;

    exp_instr_t exp_q[$];
    exp_store_t st_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push_instr(input logic [19:0] i, input logic [19:0] m, input logic v, input logic [4:0] p);
        exp_instr_t e;
        e.instr = i; e.imm = m; e.imv = v; e.pc = p;
        exp_q.push_back(e);
    endtask

    // Monitor: a new instruction is presented whenever valid is high and the PC moved.
    logic [4:0] prev_pc = 5'd0;
    always @(negedge Clock) begin
        exp_instr_t e;
        exp_store_t s;
        if (Resetn === 1'b1 && instr_valid && pc_out != prev_pc) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_instr", {12'h0, instr}, 32'hFFFFFFFF);
            end else begin
                e = exp_q.pop_front();
                chk("mon_instr", {12'h0, instr}, {12'h0, e.instr});
                chk("mon_imm_valid", {31'h0, imm_valid}, {31'h0, e.imv});
                chk("mon_pc", {27'h0, pc_out}, {27'h0, e.pc});
                if (e.imv) chk("mon_imm", {12'h0, imm}, {12'h0, e.imm});
            end
        end
        if (mem_wr_en) begin
            if (st_q.size() == 0) begin
                chk("unexpected_write", {7'h0, mem_addr, mem_data}, 32'hFFFFFFFF);
            end else begin
                s = st_q.pop_front();
                chk("mon_st_addr", {27'h0, mem_addr}, {27'h0, s.addr});
                chk("mon_st_data", {12'h0, mem_data}, {12'h0, s.data});
            end
        end
        prev_pc <= pc_out;
    end

    task automatic step_one();
        @(negedge Clock);
        stall = 1'b0;
        @(posedge Clock);
        #1 stall = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge Clock);
            n++;
        end
        @(negedge Clock);
        chk("drain_instr_q", exp_q.size(), 0);
    endtask

    task automatic do_store(input logic [4:0] a, input logic [19:0] d);
        exp_store_t s;
        int wr_cnt = 0;
        int n = 0;
        s.addr = a; s.data = d;
        st_q.push_back(s);
        st_req = 1'b1; st_addr = a; st_data = d;
        while (st_ack !== 1'b1 && n < 10) begin
            @(negedge Clock);
            if (mem_wr_en) wr_cnt++;
            n++;
        end
        chk("st_ack_seen", {31'h0, st_ack}, 32'h1);
        // Keep the request high across the ack edge; it must not be taken again.
        @(posedge Clock);
        #1 st_req = 1'b0;
        chk("st_ack_pulse", {31'h0, st_ack}, 32'h0);
        repeat (2) begin
            @(negedge Clock);
            if (mem_wr_en) wr_cnt++;
        end
        chk("wr_en_cycles", wr_cnt, 1);
        chk("mem_written", {12'h0, mem[a]}, {12'h0, d});
    endtask

    initial begin
        Resetn = 1'b0; stall = 1'b1; flush = 1'b0; flush_pc = '0;
        st_req = 1'b0; st_addr = '0; st_data = '0;
        repeat (3) @(negedge Clock);
        chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_imm_valid", {31'h0, imm_valid}, 32'h0);
        chk("rst_pc", {27'h0, pc_out}, 32'h0);
        chk("rst_instr", {12'h0, instr}, 32'h0);
        chk("rst_imm", {12'h0, imm}, 32'h0);
        chk("rst_st_ack", {31'h0, st_ack}, 32'h0);
        chk("rst_wr_en", {31'h0, mem_wr_en}, 32'h0);

        // Two-word instruction at 0 with its immediate at 1.
        push_instr(20'hF0000, 20'h00003, 1'b1, 5'd2);
        @(negedge Clock);
        Resetn = 1'b1;
        @(posedge Clock);
        @(posedge Clock);
        #1;
        chk("boot_instr", {12'h0, instr}, 32'hF0000);
        chk("boot_imm", {12'h0, imm}, 32'h00003);
        chk("boot_valid", {30'h0, instr_valid, imm_valid}, 32'h3);
        chk("boot_pc", {27'h0, pc_out}, 32'h2);
        drain();

        // One-word instruction held under stall.
        push_instr(20'h01230, 20'h0, 1'b0, 5'd3);
        step_one();
        repeat (3) begin
            @(negedge Clock);
            chk("stall_instr", {12'h0, instr}, 32'h01230);
            chk("stall_pc", {27'h0, pc_out}, 32'h3);
            chk("stall_wr_en", {31'h0, mem_wr_en}, 32'h0);
        end
        drain();

        // Store issued while waiting for an immediate.
        push_instr(20'hF4444, 20'h00044, 1'b1, 5'd5);
        step_one();
        do_store(5'd10, 20'h12345);
        drain();
        chk("after_store_imm", {12'h0, imm}, 32'h00044);

        // Store while stalled leaves the presented instruction alone.
        do_store(5'd0, 20'h00005);
        chk("stalled_store_instr", {12'h0, instr}, 32'hF4444);
        chk("stalled_store_valid", {30'h0, instr_valid, imm_valid}, 32'h3);
        chk("stalled_store_pc", {27'h0, pc_out}, 32'h5);

        // Flush while in S_IMM abandons the two-word instruction at 5.
        push_instr(20'h07777, 20'h0, 1'b0, 5'd8);
        step_one();
        flush = 1'b1; flush_pc = 5'd7;
        @(posedge Clock);
        #1 flush = 1'b0;
        chk("flush_valid", {31'h0, instr_valid}, 32'h0);
        chk("flush_pc", {27'h0, pc_out}, 32'h7);
        drain();

        // Two-word instruction at 31 takes its immediate from address 0.
        push_instr(20'hF2000, 20'h00005, 1'b1, 5'd1);
        flush = 1'b1; flush_pc = 5'd31;
        @(posedge Clock);
        #1 flush = 1'b0;
        chk("wrap_flush_pc", {27'h0, pc_out}, 32'd31);
        drain();

        // Store to the next-fetch address is seen by that fetch.
        do_store(5'd1, 20'h0ABCD);
        push_instr(20'h0ABCD, 20'h0, 1'b0, 5'd2);
        step_one();
        drain();

        // Reset in the middle of a store.
        @(negedge Clock);
        st_q.push_back('{addr: 5'd12, data: 20'h11111});
        st_req = 1'b1; st_addr = 5'd12; st_data = 20'h11111;
        @(posedge Clock);
        @(negedge Clock);
        chk("mid_store_wr_en", {31'h0, mem_wr_en}, 32'h1);
        #2 Resetn = 1'b0;
        #1;
        chk("rst_store_wr_en", {31'h0, mem_wr_en}, 32'h0);
        chk("rst_store_ack", {31'h0, st_ack}, 32'h0);
        chk("rst_store_pc", {27'h0, pc_out}, 32'h0);
        chk("rst_store_valid", {31'h0, instr_valid}, 32'h0);
        st_req = 1'b0;
        push_instr(20'h00005, 20'h0, 1'b0, 5'd1);
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
        drain();
        chk("reset_store_mem", {12'h0, mem[12]}, 32'h11111);
        chk("store_q_empty", st_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
